// File: rtl/io_hub_pkg.sv
// Shared constants and helpers for the memory-mapped IO hub.
package io_hub_pkg;

  localparam logic [4:0] OFF_LED     = 5'h00;
  localparam logic [4:0] OFF_SW      = 5'h04;
  localparam logic [4:0] OFF_SEGVAL  = 5'h08;
  localparam logic [4:0] OFF_SEGCTRL = 5'h0C;
  localparam logic [4:0] OFF_EVT     = 5'h10;

  localparam int LZS_BIT = 16;

  // Map a hex nibble to its seven-segment pattern {dp,g..a}, decimal point off.
  function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex2seg = 8'h3F;
      4'h1:    hex2seg = 8'h06;
      4'h2:    hex2seg = 8'h5B;
      4'h3:    hex2seg = 8'h4F;
      4'h4:    hex2seg = 8'h66;
      4'h5:    hex2seg = 8'h6D;
      4'h6:    hex2seg = 8'h7D;
      4'h7:    hex2seg = 8'h07;
      4'h8:    hex2seg = 8'h7F;
      4'h9:    hex2seg = 8'h6F;
      4'hA:    hex2seg = 8'h77;
      4'hB:    hex2seg = 8'h7C;
      4'hC:    hex2seg = 8'h39;
      4'hD:    hex2seg = 8'h5E;
      4'hE:    hex2seg = 8'h79;
      default: hex2seg = 8'h71;
    endcase
  endfunction

endpackage

// File: rtl/io_hub_sw_debounce.sv
// Switch conditioning: two-flop synchroniser followed by a per-bit
// stability counter that only accepts a change once it has held steady.
module sw_debounce
  import io_hub_pkg::*;
#(
  parameter int W            = 16,
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] switch_i,
  output logic [W-1:0] sw_stable_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [W-1:0]  sync1_q;
  logic [W-1:0]  sync2_q;
  logic [W-1:0]  stable_q;
  logic [W-1:0]  stable_d;
  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];

  // Count consecutive cycles the synchronised input disagrees with the accepted value.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Synchroniser flops, counters and accepted switch state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= switch_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable_o = stable_q;

endmodule

// File: rtl/io_hub.sv
// Memory-mapped IO hub: LED latch, debounced switches with sticky
// rising-edge flags, and a scanning two-bank hex display.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'hFFFF_FC00),
  parameter int                SW_W         = 16,
  parameter int                LED_W        = 16,
  parameter int                DIGITS       = 8,
  parameter int                SCAN_DIV     = 100000,
  parameter int                DEBOUNCE_CYC = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch_in,
  output logic [LED_W-1:0]  led_out,
  output logic [7:0]        seg_data,
  output logic [7:0]        seg_data2,
  output logic [DIGITS-1:0] seg_cs
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic                  hit;
  logic [4:0]            offset;
  logic                  wrLed;
  logic                  wrSegVal;
  logic                  wrSegCtrl;
  logic                  wrEvt;
  logic                  unusedAddrBits;

  logic [LED_W-1:0]      ledReg_q;
  logic [4*DIGITS-1:0]   segVal_q;
  logic [DIGITS-1:0]     blankMask_q;
  logic                  lzs_q;

  logic [SW_W-1:0]       swStable;
  logic [SW_W-1:0]       swPrev_q;
  logic [SW_W-1:0]       swEvt_q;
  logic [SW_W-1:0]       swEvt_d;

  logic [31:0]           rdataW;

  logic [DW-1:0]         divCnt_q;
  logic [DW-1:0]         divCnt_d;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;

  logic [3:0]            curNibble;
  logic                  maskBit;
  logic                  upperZero;
  logic                  blank;
  logic                  lowBank;
  logic [DIGITS-1:0]     segCs_q;
  logic [DIGITS-1:0]     segCs_d;
  logic [7:0]            segData_q;
  logic [7:0]            segData_d;
  logic [7:0]            segData2_q;
  logic [7:0]            segData2_d;

  assign hit       = (addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign offset    = addr[4:0];
  assign wrLed     = io_wr && hit && (offset == OFF_LED);
  assign wrSegVal  = io_wr && hit && (offset == OFF_SEGVAL);
  assign wrSegCtrl = io_wr && hit && (offset == OFF_SEGCTRL);
  assign wrEvt     = io_wr && hit && (offset == OFF_EVT);

  assign unusedAddrBits = ^addr[7:5];

  sw_debounce #(
    .W            (SW_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .switch_i    (switch_in),
    .sw_stable_o (swStable)
  );

  // Sticky rising-edge flags; a new edge outranks a same-cycle clear.
  always_comb begin
    swEvt_d = swEvt_q;
    if (wrEvt) begin
      swEvt_d = swEvt_d & ~wdata[SW_W-1:0];
    end
    swEvt_d = swEvt_d | (swStable & ~swPrev_q);
  end

  // Software-visible registers and edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      ledReg_q    <= '0;
      segVal_q    <= '0;
      blankMask_q <= '0;
      lzs_q       <= 1'b0;
      swPrev_q    <= '0;
      swEvt_q     <= '0;
    end else begin
      if (wrLed) begin
        ledReg_q <= wdata[LED_W-1:0];
      end
      if (wrSegVal) begin
        segVal_q <= wdata[4*DIGITS-1:0];
      end
      if (wrSegCtrl) begin
        blankMask_q <= wdata[DIGITS-1:0];
        lzs_q       <= wdata[LZS_BIT];
      end
      swPrev_q <= swStable;
      swEvt_q  <= swEvt_d;
    end
  end

  // Zero-wait-state load mux; anything not a mapped hit reads as zero.
  always_comb begin
    rdataW = '0;
    if (io_rd && hit) begin
      case (offset)
        OFF_LED:     rdataW[LED_W-1:0] = ledReg_q;
        OFF_SW:      rdataW[SW_W-1:0] = swStable;
        OFF_SEGVAL:  rdataW[4*DIGITS-1:0] = segVal_q;
        OFF_SEGCTRL: begin
          rdataW[DIGITS-1:0] = blankMask_q;
          rdataW[LZS_BIT]    = lzs_q;
        end
        OFF_EVT:     rdataW[SW_W-1:0] = swEvt_q;
        default:     rdataW = '0;
      endcase
    end
  end

  assign rdata = rdataW;

  // Scan timing: hold each digit for SCAN_DIV cycles, then step to the next.
  always_comb begin
    divCnt_d = divCnt_q + DW'(1);
    idx_d    = idx_q;
    if (divCnt_q == DW'(SCAN_DIV - 1)) begin
      divCnt_d = '0;
      idx_d    = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Pick the current digit, decide blanking and steer it to the right bank.
  always_comb begin
    curNibble = '0;
    maskBit   = 1'b0;
    upperZero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        curNibble = segVal_q[4*i +: 4];
        maskBit   = blankMask_q[i];
      end
      if ((IW'(i) >= idx_q) && (segVal_q[4*i +: 4] != 4'h0)) begin
        upperZero = 1'b0;
      end
    end
    blank      = maskBit || (lzs_q && (idx_q != '0) && upperZero);
    lowBank    = (idx_q < IW'(DIGITS / 2));
    segCs_d    = blank ? '0 : (DIGITS'(1) << idx_q);
    segData_d  = (!blank && lowBank)  ? hex2seg(curNibble) : 8'h00;
    segData2_d = (!blank && !lowBank) ? hex2seg(curNibble) : 8'h00;
  end

  // Scan counters and registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q   <= '0;
      idx_q      <= '0;
      segCs_q    <= '0;
      segData_q  <= '0;
      segData2_q <= '0;
    end else begin
      divCnt_q   <= divCnt_d;
      idx_q      <= idx_d;
      segCs_q    <= segCs_d;
      segData_q  <= segData_d;
      segData2_q <= segData2_d;
    end
  end

  assign led_out   = rst ? '0 : ledReg_q;
  assign seg_cs    = rst ? '0 : segCs_q;
  assign seg_data  = rst ? '0 : segData_q;
  assign seg_data2 = rst ? '0 : segData2_q;

endmodule
